// File: rtl/collision_engine.sv
// ============================================================================
//  Module   : collision_engine
//  Purpose  : Per-frame missile/enemy-grid and missile/player collision checks
//             with a hit FIFO, kill pulses and a player invulnerability window.
//             Optional missile-vs-missile cancel via `MISSILE_CANCEL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_engine #(
    parameter int N_PM       = 2,
    parameter int N_EM       = 4,
    parameter int COLS       = 10,
    parameter int ROWS       = 6,
    parameter int CELL_W     = 64,
    parameter int SPRITE_W   = 32,
    parameter int CELL_H     = 32,
    parameter int GRID_TOP   = 32,
    parameter int PLAYER_W   = 64,
    parameter int PLAYER_TOP = 452,
    parameter int PLAYER_BOT = 480,
    parameter int INVULN     = 60,
    parameter int DEPTH      = 4
) (
    input  logic                      vsync,
    input  logic                      reset,
    input  logic [N_PM*10-1:0]        pm_x,
    input  logic [N_PM*10-1:0]        pm_y,
    input  logic [N_PM-1:0]           pm_active,
    input  logic [N_EM*10-1:0]        em_x,
    input  logic [N_EM*10-1:0]        em_y,
    input  logic [N_EM-1:0]           em_active,
    input  logic [9:0]                player_x,
    input  logic [9:0]                enemy_offset,
    input  logic [COLS*ROWS-1:0]      enemy_status,
    output logic                      hit_valid,
    output logic [$clog2(COLS)-1:0]   hit_col,
    output logic [$clog2(ROWS)-1:0]   hit_row,
    input  logic                      hit_ready,
    output logic [N_PM-1:0]           pm_kill,
    output logic [N_EM-1:0]           em_kill,
    output logic                      pcollision,
    output logic                      invuln,
    output logic                      overflow
);

    localparam int C_CW    = $clog2(COLS);
    localparam int C_RW    = $clog2(ROWS);
    localparam int C_EW    = C_CW + C_RW;
    localparam int C_NC    = COLS * ROWS;
    localparam int C_IDX_W = $clog2(C_NC);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam int C_INV_W = $clog2(INVULN + 1);

    // FIFO is a shift register: entry 0 is always the head, {col,row} packed
    logic [C_EW-1:0]    r_q [DEPTH];
    logic [C_CNT_W-1:0] r_count;
    logic [C_NC-1:0]    r_pending;
    logic [N_PM-1:0]    r_pm_kill;
    logic [N_EM-1:0]    r_em_kill;
    logic               r_pcoll;
    logic [C_INV_W-1:0] r_counter;
    logic               r_overflow;

    logic [C_EW-1:0]    w_q_next [DEPTH];
    logic [C_CNT_W-1:0] w_count_next;
    logic [C_NC-1:0]    w_pending_next;
    logic               w_pop;
    logic               w_drop;
    logic [N_PM-1:0]    w_pm_hit;
    logic [N_EM-1:0]    w_em_hit;
    logic [N_PM-1:0]    w_pm_cancel;
    logic [N_EM-1:0]    w_em_cancel;
    logic [10:0]        w_player_right;

`ifdef MISSILE_CANCEL_EN
    always_comb begin : p_cancel
        int  dx;
        int  dy;
        logic paired;
        w_pm_cancel = '0;
        w_em_cancel = '0;
        for (int i = 0; i < N_PM; i++) begin
            paired = 1'b0;
            for (int j = 0; j < N_EM; j++) begin
                dx = int'(pm_x[10*i +: 10]) - int'(em_x[10*j +: 10]);
                dy = int'(pm_y[10*i +: 10]) - int'(em_y[10*j +: 10]);
                if (!paired && pm_active[i] && em_active[j] && !w_em_cancel[j] &&
                    dx > -8 && dx < 8 && dy > -8 && dy < 8) begin
                    w_pm_cancel[i] = 1'b1;
                    w_em_cancel[j] = 1'b1;
                    paired         = 1'b1;
                end
            end
        end
    end
`else
    assign w_pm_cancel = '0;
    assign w_em_cancel = '0;
`endif

    always_comb begin : p_grid
        int px;
        int py;
        int nx;
        int col;
        int row;
        int idx;
        int hidx;
        int wpos;
        logic [C_NC-1:0] claimed;

        w_pop          = (r_count != '0) && hit_ready;
        w_q_next       = r_q;
        w_pending_next = r_pending;
        w_pm_hit       = '0;
        w_drop         = 1'b0;
        claimed        = '0;
        nx             = 0;
        col            = 0;
        row            = 0;
        idx            = 0;
        hidx           = 0;

        if (w_pop) begin
            hidx = int'(r_q[0][C_EW-1:C_RW]) * ROWS + int'(r_q[0][C_RW-1:0]);
            w_pending_next[C_IDX_W'(hidx)] = 1'b0;
            for (int k = 0; k < DEPTH - 1; k++) begin
                w_q_next[k] = r_q[k+1];
            end
        end
        wpos = int'(r_count) - (w_pop ? 1 : 0);

        // Ascending index gives push order and lowest-index-wins on shared cells
        for (int i = 0; i < N_PM; i++) begin
            px = int'(pm_x[10*i +: 10]);
            py = int'(pm_y[10*i +: 10]);
            if (pm_active[i] && !w_pm_cancel[i] &&
                px >= int'(enemy_offset) && py >= GRID_TOP) begin
                nx  = px - int'(enemy_offset);
                col = nx / CELL_W;
                row = (py - GRID_TOP) / CELL_H;
                if (col < COLS && (nx % CELL_W) < SPRITE_W && row < ROWS) begin
                    idx = col * ROWS + row;
                    if (enemy_status[C_IDX_W'(idx)] && !r_pending[C_IDX_W'(idx)] &&
                        !claimed[C_IDX_W'(idx)]) begin
                        claimed[C_IDX_W'(idx)] = 1'b1;
                        if (wpos < DEPTH) begin
                            w_q_next[C_PTR_W'(wpos)]       = {C_CW'(col), C_RW'(row)};
                            w_pending_next[C_IDX_W'(idx)] = 1'b1;
                            w_pm_hit[i]                   = 1'b1;
                            wpos                          = wpos + 1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end
            end
        end
        w_count_next = C_CNT_W'(wpos);
    end

    // Right edge is inclusive and computed one bit wider so it cannot wrap
    assign w_player_right = {1'b0, player_x} + 11'(PLAYER_W);

    always_comb begin : p_player
        int ex;
        int ey;
        w_em_hit = '0;
        for (int j = 0; j < N_EM; j++) begin
            ex = int'(em_x[10*j +: 10]);
            ey = int'(em_y[10*j +: 10]);
            if (em_active[j] && !w_em_cancel[j] &&
                ey >= PLAYER_TOP && ey < PLAYER_BOT &&
                ex >= int'(player_x) && ex <= int'(w_player_right)) begin
                w_em_hit[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge vsync) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_q[k] <= '0;
            end
            r_count    <= '0;
            r_pending  <= '0;
            r_pm_kill  <= '0;
            r_em_kill  <= '0;
            r_pcoll    <= 1'b0;
            r_counter  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_q        <= w_q_next;
            r_count    <= w_count_next;
            r_pending  <= w_pending_next;
            r_pm_kill  <= w_pm_hit | w_pm_cancel;
            r_em_kill  <= w_em_hit | w_em_cancel;
            r_pcoll    <= 1'b0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // A hit during the window never reloads it
            if (r_counter != '0) begin
                r_counter <= r_counter - 1'b1;
            end else if (|w_em_hit) begin
                r_pcoll   <= 1'b1;
                r_counter <= C_INV_W'(INVULN);
            end
        end
    end

    assign hit_valid  = (r_count != '0);
    assign hit_col    = r_q[0][C_EW-1:C_RW];
    assign hit_row    = r_q[0][C_RW-1:0];
    assign pm_kill    = r_pm_kill;
    assign em_kill    = r_em_kill;
    assign pcollision = r_pcoll;
    assign invuln     = (r_counter != '0);
    assign overflow   = r_overflow;

endmodule

`default_nettype wire
